muldiv_unit: RTL and testbench

- Parametrised, iterative multiply/divide execution unit for RV32M/RV64M: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits in EX beside the single-cycle ALU. Decode steers M-extension ops here.
- Valid/ready handshake on both sides; EX stalls while the unit is busy.
- Radix-2 shift-add multiply, restoring divide, one bit per cycle. Fast path for divide special cases.

---
 rtl/md_pkg.sv | 42 ++++
 rtl/md_div_step.sv | 23 ++
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings follow funct3 of the RV32M/RV64M instructions.
package md_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic want_high(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic want_rem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module md_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {2'b00, div_i});
        diff    = shifted[XLEN:0] - {1'b0, div_i};
        rem_o   = q_o ? diff : shifted[XLEN:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit for the M extension.
// Operands are reduced to magnitudes on accept; signs are fixed in ST_FIX.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = (XLEN == 64) ? 7 : 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e           state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                neg_q, neg_d;
    logic                neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                accept;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_rem;
    logic                div_q;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rmd, fix_res;

    md_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (acc_q[XLEN-1]),
        .div_i (b_q),
        .rem_o (div_rem),
        .q_o   (div_q)
    );

    always_comb begin
        a_neg = is_signed_a(in_op) && in_a[XLEN-1];
        b_neg = is_signed_b(in_op) && in_b[XLEN-1];
        a_mag = a_neg ? -in_a : in_a;
        b_mag = b_neg ? -in_b : in_b;

        div_zero = is_div(in_op) && (in_b == '0);
        div_ovf  = is_div(in_op) && is_signed_b(in_op) &&
                   (in_a == MIN_INT) && (in_b == '1);

        if (div_zero) begin
            special_res = want_rem(in_op) ? in_a : '1;
        end else begin
            special_res = want_rem(in_op) ? '0 : MIN_INT;
        end
    end

    // Shift-add: add the multiplicand when the product LSB is set.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rmd  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        if (is_div(op_q)) begin
            fix_res = want_rem(op_q) ? rmd : quo;
        end else begin
            fix_res = want_high(op_q) ? prod[2*XLEN-1:XLEN]
                                      : prod[XLEN-1:0];
        end
    end

    assign accept = in_valid && (state_q == ST_IDLE) && !flush;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        b_d       = b_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        res_d     = res_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = in_op;
                    tag_d     = in_tag;
                    acc_d     = {{XLEN{1'b0}}, a_mag};
                    rem_d     = '0;
                    b_d       = b_mag;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = CNT_LAST;
                    if (div_zero || div_ovf) begin
                        res_d   = special_res;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (is_div(op_q)) begin
                    acc_d = {acc_q[2*XLEN-1:XLEN],
                             acc_q[XLEN-2:0], div_q};
                    rem_d = div_rem;
                end else begin
                    acc_d = mul_next;
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                res_d   = fix_res;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A redirect drops whatever is in flight.
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            tag_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at XLEN=32.
// Expected results are hand-computed constants.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'b000;
    logic [XLEN-1:0]  in_a = '0;
    logic [XLEN-1:0]  in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for out_valid; lat counts samples after the accept edge.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tg,
                          output logic [31:0] res, output logic [4:0] rt,
                          output int lat);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tg;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        res = out_result;
        rt  = out_tag;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic vec(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, input logic [31:0] exp,
                       input int exp_lat);
        logic [31:0] res;
        logic [4:0]  rt;
        int          lat;
        run_op(op, a, b, tg, res, rt, lat);
        check(name, res, exp);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_tag"}, rt, tg);
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rt;
        int          lat;
        int          seen;

        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", out_result, 0);
        check("rst_tag", out_tag, 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vec("mul_m1x7",    3'b000, 32'hFFFF_FFFF, 32'd7,         5'd5,  32'hFFFF_FFF9, 34);
        vec("mulh_min2",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 34);
        vec("mulhu_min2",  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 34);
        vec("mulhsu_m1",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34);
        vec("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 34);
        vec("mul_3xm5",    3'b000, 32'd3,         32'hFFFF_FFFB, 5'd10, 32'hFFFF_FFF1, 34);
        vec("mulh_3xm5",   3'b001, 32'd3,         32'hFFFF_FFFB, 5'd11, 32'hFFFF_FFFF, 34);
        vec("mul_zero",    3'b000, 32'h1234_5678, 32'd0,         5'd12, 32'h0,         34);

        vec("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFD, 34);
        vec("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFF, 34);
        vec("divu_7_2",    3'b101, 32'd7,         32'd2,         5'd15, 32'd3,         34);
        vec("remu_7_2",    3'b111, 32'd7,         32'd2,         5'd16, 32'd1,         34);
        vec("div_100_m7",  3'b100, 32'd100,       32'hFFFF_FFF9, 5'd17, 32'hFFFF_FFF2, 34);
        vec("rem_100_m7",  3'b110, 32'd100,       32'hFFFF_FFF9, 5'd18, 32'd2,         34);
        vec("divu_big",    3'b101, 32'hFFFF_FFFF, 32'h10,        5'd19, 32'h0FFF_FFFF, 34);
        vec("remu_big",    3'b111, 32'hFFFF_FFFF, 32'h10,        5'd20, 32'hF,         34);
        vec("divu_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h0,         34);
        vec("remu_min_m1", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 34);

        vec("div_by0",     3'b100, 32'h1234,      32'd0,         5'd23, 32'hFFFF_FFFF, 1);
        vec("divu_by0",    3'b101, 32'h1234,      32'd0,         5'd24, 32'hFFFF_FFFF, 1);
        vec("rem_by0",     3'b110, 32'h1234,      32'd0,         5'd25, 32'h1234,      1);
        vec("remu_by0",    3'b111, 32'h1234,      32'd0,         5'd26, 32'h1234,      1);
        vec("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd27, 32'h8000_0000, 1);
        vec("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd28, 32'h0,         1);

        // Backpressure: hold the result, keep a new request pending.
        in_op = 3'b101; in_a = 32'd7; in_b = 32'd2; in_tag = 5'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check("bp_lat", lat, 34);
        in_op = 3'b000; in_a = 32'd6; in_b = 32'd7; in_tag = 5'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_result", out_result, 32'd3);
            check("bp_tag", out_tag, 5'd9);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_ready", in_ready, 1);
        check("bp_idle_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_busy", busy, 1);
        wait_result(lat);
        check("bp_next_lat", lat, 34);
        check("bp_next_result", out_result, 32'd42);
        check("bp_next_tag", out_tag, 5'd3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Flush during CALC cycle 10.
        in_op = 3'b000; in_a = 32'd5; in_b = 32'd5; in_tag = 5'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("fl_calc_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_busy", busy, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_out_valid", out_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("fl_no_result", seen, 0);

        // Flush with a request in IDLE: request must be dropped.
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("fl_idle_busy", busy, 0);
        vec("after_flush", 3'b011, 32'hFFFF_FFFF, 32'd2, 5'd30, 32'd1, 34);

        // Asynchronous reset mid-CALC.
        in_op = 3'b000; in_a = 32'd3; in_b = 32'd5; in_tag = 5'd31;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_in_ready", in_ready, 1);
        check("ar_busy", busy, 0);
        check("ar_out_valid", out_valid, 0);
        check("ar_result", out_result, 0);
        check("ar_tag", out_tag, 0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_stay_idle", busy, 0);
        run_op(3'b100, 32'hFFFF_FF9C, 32'd10, 5'd2, res, rt, lat);
        check("ar_div", res, 32'hFFFF_FFF6);
        check("ar_div_lat", lat, 34);
        check("ar_div_tag", rt, 5'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
